// File: rtl/core_wb_ldm.sv
// Write-side controller for the GPR file: merges single-cycle ALU results with
// the load-multiple beat stream onto one registered writeback port.
module core_wb_ldm #(
  parameter int NREGS     = 15,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid_i,
  input  logic [3:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        ldm_start_i,
  input  logic [15:0] ldm_reglist_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic        ldm_busy_o,
  output logic        ldm_done_o,
  output logic        wb_o,
  output logic [3:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [16:0] ONE17    = 17'd1;
  localparam logic [15:0] REG_MASK = 16'((ONE17 << NREGS) - ONE17);
  localparam logic [4:0]  NREGS_W  = 5'(NREGS);
  localparam logic [CW-1:0] DEPTH_W = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [15:0]     tagmask_q;
  logic [4:0]      left_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      buf_tag_q  [BUF_DEPTH];
  logic [31:0]     buf_data_q [BUF_DEPTH];
  logic            wb_q;
  logic [3:0]      wb_addr_q;
  logic [31:0]     wb_data_q;

  logic [15:0] start_mask;
  logic [3:0]  tag;
  logic        push, pop, last_pop;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Next beat goes to the lowest register still waiting for data.
  always_comb begin
    tag = '0;
    for (int i = 15; i >= 0; i--) if (tagmask_q[i]) tag = 4'(i);
  end

  assign start_mask  = ldm_reglist_i & REG_MASK;
  assign mem_ready_o = (state_q == RUN) && (cnt_q != DEPTH_W) && (tagmask_q != '0);
  assign push        = mem_valid_i && mem_ready_o;
  assign pop         = !alu_valid_i && (cnt_q != '0);
  assign last_pop    = pop && (left_q == 5'd1);
  assign ldm_busy_o  = (state_q == RUN);
  assign ldm_done_o  = (state_q == DONE);
  assign wb_o        = wb_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_tag_q[wptr_q]  <= tag;
      buf_data_q[wptr_q] <= mem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tagmask_q <= '0;
      left_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      wb_q      <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      // ALU always wins the port; an out-of-range ALU target still stalls the drain.
      wb_q <= 1'b0;
      if (alu_valid_i) begin
        wb_q      <= ({1'b0, alu_addr_i} < NREGS_W);
        wb_addr_q <= alu_addr_i;
        wb_data_q <= alu_data_i;
      end else if (pop) begin
        wb_q      <= 1'b1;
        wb_addr_q <= buf_tag_q[rptr_q];
        wb_data_q <= buf_data_q[rptr_q];
      end

      if (push) begin
        wptr_q    <= wptr_q + PW'(1);
        tagmask_q <= tagmask_q & (tagmask_q - 16'd1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        left_q <= left_q - 5'd1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);

      case (state_q)
        IDLE: if (ldm_start_i) begin
          tagmask_q <= start_mask;
          left_q    <= popcnt(start_mask);
          state_q   <= (start_mask != '0) ? RUN : DONE;
        end
        RUN:     if (last_pop) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/core_wb_ldm.md
Name: core_wb_ldm

Overview:
- Write-side controller for the GPR file; drives its single writeback port (wb, wb_addr, wb_data).
- Merges two producers:
  - single-cycle ALU results;
  - the load-multiple (LDM) data stream from the memory unit, with a 16-bit register list.
- Reads from the GPR file are unaffected.

Parameters:
- NREGS, 15, number of implemented GPRs; writes to addresses >= NREGS are suppressed.
- BUF_DEPTH, 2, memory-beat skid buffer entries (power of 2, >= 2).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result present this cycle; always accepted.
- alu_addr  input  4  ALU destination register.
- alu_data  input  32  ALU result.
- ldm_start  input  1  one-cycle pulse; begin LDM with ldm_reglist.
- ldm_reglist  input  16  bit i set = load register i; sampled on ldm_start.
- mem_valid  input  1  memory beat offered.
- mem_data  input  32  memory beat data.
- mem_ready  output  1  beat accepted when mem_valid && mem_ready.
- ldm_busy  output  1  LDM in progress.
- ldm_done  output  1  one-cycle pulse after the last LDM write.
- wb  output  1  GPR write enable.
- wb_addr  output  4  GPR write address.
- wb_data  output  32  GPR write data.

Behaviour:
- Reset values (asynchronous): wb=0, wb_addr=0, wb_data=0, mem_ready=0, ldm_busy=0, ldm_done=0. Buffer is emptied and state is IDLE.
- All wb outputs are registered.

ALU path:
- alu_valid in cycle N gives wb=1 with alu_addr/alu_data in cycle N+1.
- The ALU has absolute priority over the LDM path.
- alu_addr >= NREGS: wb stays 0 that cycle. The result is dropped, with no error.

LDM state machine: IDLE, RUN, DONE.
- IDLE:
  - ldm_start latches pending = ldm_reglist with bits >= NREGS cleared.
  - If pending is nonzero, go to RUN. If pending is zero, go to DONE (no memory beats are requested).
  - ldm_start while not IDLE is ignored.
- RUN:
  - ldm_busy=1.
  - mem_ready = (buffer not full) && (beats accepted < popcount(pending at start)).
  - Each accepted beat is pushed with tag = lowest set bit of the not-yet-tagged mask; that bit is then cleared from the tag mask.
  - Order is ascending register number.
- Buffer drain:
  - In any cycle with alu_valid=0 and buffer non-empty, pop the head; wb=1 next cycle with tag/data.
  - A beat accepted in cycle N is written no earlier than N+2 (push N, pop N+1, wb visible N+2).
  - Simultaneous push and pop in the same cycle is allowed when full; ready stays 1 in that case is NOT required — mem_ready is computed from the registered occupancy only.
- When the final tagged beat has been popped, go to DONE.
- DONE: ldm_done=1 for exactly one cycle, ldm_busy=0, then IDLE.
  - ldm_done is asserted the same cycle the last wb for that LDM is visible.
  - For an empty list, DONE follows ldm_start by one cycle.
- mem_ready=0 outside RUN. mem_valid outside RUN is ignored and not consumed.
- Back-to-back ALU results stall the LDM drain indefinitely. No beat is lost; mem_ready drops when the buffer is full.
- Mid-operation reset: buffer contents and the remaining list are discarded, and no wb is issued after reset.
- Write-port conflicts are impossible by construction: at most one wb per cycle.

Test Plan:
- Reset, then alu_valid=1, alu_addr=3, alu_data=0xDEADBEEF -> next cycle wb=1, wb_addr=3, wb_data=0xDEADBEEF; following cycle wb=0.
- alu_addr=15 with alu_valid=1 -> wb stays 0.
- ldm_start with reglist=0x0085, mem_valid held high with data 0x11, 0x22, 0x33 -> writes r0=0x11, r2=0x22, r7=0x33 in ascending order. ldm_done pulses with the r7 write; exactly 3 beats are accepted and mem_ready=0 afterwards.
- LDM reglist=0x000F with alu_valid held high for 5 cycles from the first beat:
  - mem_ready drops after 2 buffered beats;
  - the 5 ALU writes appear first, then r0..r3;
  - no beat is lost or duplicated.
- ldm_start with reglist=0x8000 (only bit 15) -> no memory beat accepted, no wb, ldm_done 1 cycle later.
- rst_n asserted low while in RUN with 1 beat buffered -> all outputs 0 immediately. After release, no wb occurs and a new ldm_start works normally.
